edf_claim_arbiter: RTL

//   Consumer side of the EDF interrupt-controller gateway interface. Takes the

---
 rtl/edf_claim_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/edf_claim_arbiter.sv
// ---------------------------------------------------------------------------
// edf_claim_arbiter
//
// Consumer side of the EDF interrupt-controller gateway interface. A single
// comparator sweeps the NrSrc gateway cells one per cycle, tracking the
// pending source with the earliest absolute deadline. At the end of every
// sweep the winner is committed and presented to the core as one interrupt
// request. When the core acknowledges, a one-cycle claim pulse goes back to
// the winning gateway cell.
//
// Parameters
//   NrSrc    number of gateway cells / interrupt sources (>= 2)
//   TsWidth  deadline width in bits (<= 64, must match the gateway cells)
//   IdWidth  derived width of a source index
//
// Ports
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   mtime_i    in   platform timer (only used for deadline-miss detection)
//   ip_i       in   pending flag per gateway cell
//   dl_i       in   deadlines, source k at [k*TsWidth +: TsWidth]
//   claim_o    out  one-hot claim pulse back to the gateway cells
//   irq_o      out  interrupt request to the core
//   irq_id_o   out  index of the selected source
//   irq_dl_o   out  deadline of the selected source
//   irq_ack_i  in   core acknowledge, honoured only while irq_o = 1
//   dl_miss_o  out  selected deadline has already passed
//
// Configuration
//   EDF_IC_DL_MISS_EN  when defined, dl_miss_o is a registered comparison of
//                      mtime_i against the selected deadline. When undefined,
//                      dl_miss_o is tied low and mtime_i is ignored.
// ---------------------------------------------------------------------------
module edf_claim_arbiter #(
    parameter int unsigned NrSrc   = 8,
    parameter int unsigned TsWidth = 64,
    localparam int unsigned IdWidth = $clog2(NrSrc)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [63:0]                mtime_i,
    input  logic [NrSrc-1:0]           ip_i,
    input  logic [NrSrc*TsWidth-1:0]   dl_i,
    output logic [NrSrc-1:0]           claim_o,
    output logic                       irq_o,
    output logic [IdWidth-1:0]         irq_id_o,
    output logic [TsWidth-1:0]         irq_dl_o,
    input  logic                       irq_ack_i,
    output logic                       dl_miss_o
);

    // FSM encoding
    localparam logic [0:0] StSweep = 1'b0;
    localparam logic [0:0] StClaim = 1'b1;

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrSrc - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic [IdWidth-1:0] idx_q, idx_d;

    // Running candidate of the current sweep
    logic               cand_valid_q, cand_valid_d;
    logic [IdWidth-1:0] cand_id_q, cand_id_d;
    logic [TsWidth-1:0] cand_dl_q, cand_dl_d;

    // Committed selection presented to the core
    logic               sel_valid_q, sel_valid_d;
    logic [IdWidth-1:0] sel_id_q, sel_id_d;
    logic [TsWidth-1:0] sel_dl_q, sel_dl_d;

    logic [NrSrc-1:0]   claim_q, claim_d;

    // -----------------------------------------------------------------------
    // Source under inspection this cycle
    // -----------------------------------------------------------------------
    logic [TsWidth-1:0] dl_arr [NrSrc];

    for (genvar k = 0; k < NrSrc; k++) begin : g_dl
        assign dl_arr[k] = dl_i[k*TsWidth +: TsWidth];
    end

    logic               cur_ip;
    logic [TsWidth-1:0] cur_dl;
    logic               take;
    logic               scan_valid;
    logic [IdWidth-1:0] scan_id;
    logic [TsWidth-1:0] scan_dl;
    logic               ack_fire;

    assign cur_ip = ip_i[idx_q];
    assign cur_dl = dl_arr[idx_q];

    // Strict less-than: on equal deadlines the earlier (lower-index) candidate stays.
    assign take = cur_ip && (!cand_valid_q || (cur_dl < cand_dl_q));

    // Candidate including the current source; used both to advance and to commit.
    assign scan_valid = cand_valid_q | take;
    assign scan_id    = take ? idx_q  : cand_id_q;
    assign scan_dl    = take ? cur_dl : cand_dl_q;

    assign ack_fire = irq_ack_i && sel_valid_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cand_valid_d = cand_valid_q;
        cand_id_d    = cand_id_q;
        cand_dl_d    = cand_dl_q;
        sel_valid_d  = sel_valid_q;
        sel_id_d     = sel_id_q;
        sel_dl_d     = sel_dl_q;
        claim_d      = '0;

        case (state_q)
            StSweep: begin
                if (ack_fire) begin
                    // Acknowledge wins over a commit in the same cycle; the
                    // sweep restarts once the gateway has dropped its flag.
                    claim_d      = {{(NrSrc-1){1'b0}}, 1'b1} << sel_id_q;
                    sel_valid_d  = 1'b0;
                    state_d      = StClaim;
                    idx_d        = '0;
                    cand_valid_d = 1'b0;
                end else if (idx_q == LastIdx) begin
                    sel_valid_d = scan_valid;
                    if (scan_valid) begin
                        sel_id_d = scan_id;
                        sel_dl_d = scan_dl;
                    end
                    idx_d        = '0;
                    cand_valid_d = 1'b0;
                end else begin
                    idx_d        = idx_q + IdWidth'(1);
                    cand_valid_d = scan_valid;
                    cand_id_d    = scan_id;
                    cand_dl_d    = scan_dl;
                end
            end

            StClaim: begin
                // One idle cycle so the claimed gateway's registered ip clears
                // before the next sweep samples it.
                state_d      = StSweep;
                idx_d        = '0;
                cand_valid_d = 1'b0;
            end

            default: begin
                state_d      = StSweep;
                idx_d        = '0;
                cand_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StSweep;
            idx_q        <= '0;
            cand_valid_q <= 1'b0;
            cand_id_q    <= '0;
            cand_dl_q    <= '0;
            sel_valid_q  <= 1'b0;
            sel_id_q     <= '0;
            sel_dl_q     <= '0;
            claim_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cand_valid_q <= cand_valid_d;
            cand_id_q    <= cand_id_d;
            cand_dl_q    <= cand_dl_d;
            sel_valid_q  <= sel_valid_d;
            sel_id_q     <= sel_id_d;
            sel_dl_q     <= sel_dl_d;
            claim_q      <= claim_d;
        end
    end

    // -----------------------------------------------------------------------
    // Deadline-miss flag
    // -----------------------------------------------------------------------
`ifdef EDF_IC_DL_MISS_EN
    logic dl_miss_q, dl_miss_d;

    always_comb begin
        dl_miss_d = 1'b0;
        if (!ack_fire) begin
            dl_miss_d = sel_valid_q && (mtime_i[TsWidth-1:0] > sel_dl_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dl_miss_q <= 1'b0;
        end else begin
            dl_miss_q <= dl_miss_d;
        end
    end

    assign dl_miss_o = dl_miss_q;
`else
    logic unused_mtime;
    assign unused_mtime = ^mtime_i;
    assign dl_miss_o    = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign irq_o    = sel_valid_q;
    assign irq_id_o = sel_id_q;
    assign irq_dl_o = sel_dl_q;
    assign claim_o  = claim_q;

endmodule
